// File: rtl/mult16_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mult16_seq_ctrl_pkg : shared state encoding and step constants
// Revision: 1.0
// ============================================================================
package mult16_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit 0 of the step picks the high byte of a, bit 1 the high byte of b.
  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_HL = 2'd1;
  localparam logic [1:0] STEP_LH = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

  function automatic logic [7:0] byte_sel(input logic [15:0] v, input logic hi);
    return hi ? v[15:8] : v[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult16_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// mult16_seq_ctrl_if : operand/result handshakes, 8x8 core port and status
// Revision: 1.0
// ============================================================================
interface mult16_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_p;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_p;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_p,
    output in_ready, out_valid, out_p, mul_a, mul_b, busy, ops_done
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mul_p,
    input  in_ready, out_valid, out_p, mul_a, mul_b, busy, ops_done
  );
endinterface
`default_nettype wire

// File: rtl/mult16_seq_ctrl_acc.sv
`default_nettype none
// ============================================================================
// mult16_seq_ctrl_acc : operand byte muxes and 32-bit shift-accumulator
// Revision: 1.0
// ============================================================================
module mult16_seq_ctrl_acc
  import mult16_seq_ctrl_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [15:0] a_i,
  input  wire logic [15:0] b_i,
  input  wire logic [1:0]  step_i,
  input  wire logic        en_i,
  input  wire logic        clr_i,
  input  wire logic [15:0] mul_p_i,
  output logic [7:0]       mul_a_o,
  output logic [7:0]       mul_b_o,
  output logic [31:0]      acc_o
);

  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [31:0] w_term;

  // Core inputs are parked at zero when no pass is running.
  always_comb begin
    mul_a_o = 8'h00;
    mul_b_o = 8'h00;
    if (en_i) begin
      mul_a_o = byte_sel(a_i, step_i[0]);
      mul_b_o = byte_sel(b_i, step_i[1]);
    end
  end

  always_comb begin
    w_term = {16'h0000, mul_p_i};
    case (step_i)
      STEP_LL:          w_term = {16'h0000, mul_p_i};
      STEP_HL, STEP_LH: w_term = {8'h00, mul_p_i, 8'h00};
      STEP_HH:          w_term = {mul_p_i, 16'h0000};
      default:          w_term = {16'h0000, mul_p_i};
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = 32'h0000_0000;
    end else if (en_i) begin
      acc_d = (step_i == STEP_LL) ? w_term : (acc_q + w_term);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 32'h0000_0000;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/mult16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mult16_seq_ctrl : 16x16 unsigned multiply in four passes over a shared 8x8 core
// Revision: 1.0
// ============================================================================
module mult16_seq_ctrl
  import mult16_seq_ctrl_pkg::*;
#(
  parameter int SKIP_ZERO = 1,
  parameter int CNT_W     = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mult16_seq_ctrl_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic [1:0]       step_q;
  logic [1:0]       step_d;
  logic [15:0]      a_q;
  logic [15:0]      a_d;
  logic [15:0]      b_q;
  logic [15:0]      b_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_zero_op;
  logic             w_acc_clr;
  logic             w_acc_en;
  logic [31:0]      w_acc;

  // rst_n gates in_ready so nothing can be accepted while reset is held.
  assign w_in_ready = rst_n & ((state_q == ST_IDLE) |
                               ((state_q == ST_DONE) & bus.out_ready));
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_zero_op  = (SKIP_ZERO != 0) & ((bus.in_a == 16'h0000) | (bus.in_b == 16'h0000));
  assign w_acc_en   = (state_q == ST_MUL);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    w_acc_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_MUL: begin
        step_d = step_q + 2'd1;
        if (step_q == STEP_HH) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An accept in DONE overrides the fall back to IDLE: no bubble between results.
    if (w_accept) begin
      a_d       = bus.in_a;
      b_d       = bus.in_b;
      step_d    = STEP_LL;
      w_acc_clr = 1'b1;
      state_d   = w_zero_op ? ST_DONE : ST_MUL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_LL;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  mult16_seq_ctrl_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_i     (a_q),
    .b_i     (b_q),
    .step_i  (step_q),
    .en_i    (w_acc_en),
    .clr_i   (w_acc_clr),
    .mul_p_i (bus.mul_p),
    .mul_a_o (bus.mul_a),
    .mul_b_o (bus.mul_b),
    .acc_o   (w_acc)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_p     = (state_q == ST_DONE) ? w_acc : 32'h0000_0000;
  assign bus.busy      = (state_q == ST_MUL);
  assign bus.ops_done  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mult16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mult16_seq_ctrl : scoreboard bench for the sequenced 16x16 multiplier
// Revision: 1.0
// ============================================================================
module tb_mult16_seq_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mult16_seq_ctrl_if #(.CNT_W(16)) bus  ();
  mult16_seq_ctrl_if #(.CNT_W(16)) bus0 ();

  mult16_seq_ctrl #(.SKIP_ZERO(1), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mult16_seq_ctrl #(.SKIP_ZERO(0), .CNT_W(16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  // Behavioural 8x8 cores
  assign bus.mul_p  = {8'h00, bus.mul_a}  * {8'h00, bus.mul_b};
  assign bus0.mul_p = {8'h00, bus0.mul_a} * {8'h00, bus0.mul_b};

  typedef struct {
    logic [31:0] p;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   vstart = -1;

  // Latency counts clock edges from the accept edge to the first edge after
  // which out_valid is seen: 4 through the passes, 0 on the zero bypass.
  localparam int LAT_MUL = 4;
  localparam int LAT_BYP = 0;

  logic [15:0] s_a [8] = '{16'h0002, 16'h0100, 16'h8000, 16'hFFFF,
                           16'h0010, 16'h1000, 16'h00FF, 16'hFF00};
  logic [15:0] s_b [8] = '{16'h0003, 16'h0100, 16'h0002, 16'h0001,
                           16'h0010, 16'h1000, 16'h00FF, 16'h00FF};
  logic [31:0] s_p [8] = '{32'h0000_0006, 32'h0001_0000, 32'h0001_0000, 32'h0000_FFFF,
                           32'h0000_0100, 32'h0100_0000, 32'h0000_FE01, 32'h00FE_0100};
  logic [15:0] step_ab [4] = '{16'h3478, 16'h1278, 16'h3456, 16'h1256};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: pops on each result handshake and checks product and latency.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vstart = -1;
      end else begin
        if (bus.out_valid && vstart < 0) vstart = cyc;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got 0x%08h, expected no result", bus.out_p);
          end else begin
            e = exp_q.pop_front();
            check({e.name, " product"}, bus.out_p, e.p);
            check({e.name, " latency"}, 32'(vstart - e.acc), 32'(e.lat));
          end
          vstart = -1;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p,
                      input int lat, input string name, output int acc_cyc);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      timeout({name, " accept"});
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc + 1;
      exp_q.push_back('{p: p, lat: lat, acc: acc_cyc, name: name});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      timeout({name, " drain"});
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stimulus
    int ac;
    int prev;
    int t;
    int t0;
    int saw_busy;

    bus.in_valid   = 1'b0;
    bus.in_a       = 16'h0000;
    bus.in_b       = 16'h0000;
    bus.out_ready  = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.in_a      = 16'h0000;
    bus0.in_b      = 16'h0000;
    bus0.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready",  32'(bus.in_ready),  32'h0);
    check("reset out_valid", 32'(bus.out_valid), 32'h0);
    check("reset out_p",     bus.out_p,          32'h0);
    check("reset mul_ab",    {16'h0, bus.mul_a, bus.mul_b}, 32'h0);
    check("reset busy",      32'(bus.busy),      32'h0);
    check("reset ops_done",  32'(bus.ops_done),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready after release", 32'(bus.in_ready), 32'h1);

    // Zero operand without bypass still runs all four passes.
    bus0.in_valid = 1'b1;
    bus0.in_a     = 16'h0000;
    bus0.in_b     = 16'hABCD;
    @(negedge clk);
    check("noskip in_ready", 32'(bus0.in_ready), 32'h1);
    t0 = cyc + 1;
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    t = 0;
    saw_busy = 0;
    @(negedge clk);
    while (!bus0.out_valid && t < 20) begin
      if (bus0.busy) saw_busy++;
      @(negedge clk);
      t++;
    end
    if (!bus0.out_valid) timeout("noskip result");
    check("noskip latency", 32'(cyc - t0), 32'(LAT_MUL));
    check("noskip out_p",   bus0.out_p, 32'h0);
    check("noskip busy cycles", 32'(saw_busy), 32'd4);
    @(posedge clk);
    #1;

    send(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, LAT_MUL, "ffff_sq", ac);
    bus.in_valid = 1'b0;
    drain("ffff_sq");
    check("ops_done after ffff_sq", 32'(bus.ops_done), 32'd1);

    send(16'h1234, 16'h5678, 32'h0626_0060, LAT_MUL, "1234x5678", ac);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("step%0d mul_ab", i), {16'h0, bus.mul_a, bus.mul_b}, {16'h0, step_ab[i]});
      check($sformatf("step%0d busy", i), 32'(bus.busy), 32'h1);
    end
    drain("1234x5678");
    check("idle mul_ab", {16'h0, bus.mul_a, bus.mul_b}, 32'h0);
    check("idle busy", 32'(bus.busy), 32'h0);
    check("ops_done after 1234x5678", 32'(bus.ops_done), 32'd2);

    send(16'h0000, 16'hABCD, 32'h0000_0000, LAT_BYP, "zero_bypass", ac);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bypass busy", 32'(bus.busy), 32'h0);
    check("bypass mul_ab", {16'h0, bus.mul_a, bus.mul_b}, 32'h0);
    drain("zero_bypass");
    check("ops_done after bypass", 32'(bus.ops_done), 32'd3);

    // Backpressure: result held, new operands ignored until the consumer takes it.
    bus.out_ready = 1'b0;
    send(16'h00FF, 16'h0100, 32'h0000_FF00, LAT_MUL, "hold", ac);
    bus.in_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.out_valid) timeout("hold result");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0101;
    bus.in_b     = 16'h0101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold out_p",     bus.out_p,          32'h0000_FF00);
      check("hold in_ready",  32'(bus.in_ready),  32'h0);
      check("hold out_valid", 32'(bus.out_valid), 32'h1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(16'h0101, 16'h0101, 32'h0001_0201, LAT_MUL, "after_hold", ac);
    bus.in_valid = 1'b0;
    drain("after_hold");
    check("ops_done after hold", 32'(bus.ops_done), 32'd5);

    prev = -1;
    for (int i = 0; i < 8; i++) begin
      send(s_a[i], s_b[i], s_p[i], LAT_MUL, $sformatf("stream%0d", i), ac);
      if (i > 0) check($sformatf("stream%0d spacing", i), 32'(ac - prev), 32'd5);
      prev = ac;
    end
    bus.in_valid = 1'b0;
    drain("stream");
    check("ops_done after stream", 32'(bus.ops_done), 32'd13);

    // Reset in the middle of pass 2.
    send(16'h1234, 16'h5678, 32'h0626_0060, LAT_MUL, "rst_abort", ac);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort at step2", {16'h0, bus.mul_a, bus.mul_b}, 32'h0000_3456);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'h0);
    check("midrst in_ready",  32'(bus.in_ready),  32'h0);
    check("midrst busy",      32'(bus.busy),      32'h0);
    check("midrst mul_ab",    {16'h0, bus.mul_a, bus.mul_b}, 32'h0);
    check("midrst out_p",     bus.out_p,          32'h0);
    check("midrst ops_done",  32'(bus.ops_done),  32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post-reset out_valid", 32'(bus.out_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    send(16'h00AB, 16'h0CD0, 32'h0008_8EF0, LAT_MUL, "post_reset", ac);
    bus.in_valid = 1'b0;
    drain("post_reset");
    check("ops_done after reset", 32'(bus.ops_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
